// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - 4x4 matrix keypad scanner with debounce and key encoding
//
// Drives one keypad column low at a time, samples the rows once per dwell
// period and debounces both press and release before reporting a key.
//
// Ports:
//   clk    - sole clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   row    - row sense, active-low, asynchronous to clk
//   col    - column drive, active-low, exactly one bit low
//   out    - last accepted key code {row_idx, col_idx}
//   valid  - one-cycle strobe when out takes a newly accepted key
//   held   - high while the accepted key remains pressed
module keypad_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] out,
  output logic       valid,
  output logic       held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t          state, state_d;
  logic [3:0]      row_s1, row_s2;
  logic [DW-1:0]   div_cnt;
  logic [1:0]      col_idx, col_idx_d;
  logic [1:0]      cand_row, cand_row_d;
  logic [MW-1:0]   mcnt, mcnt_d;
  logic [3:0]      out_d;
  logic            valid_d, held_d;
  logic            sample;
  logic            any_low;
  logic            cand_low;
  logic [1:0]      low_idx;

  assign col      = ~(4'b0001 << col_idx);
  assign sample   = (div_cnt == DIV_LAST);
  assign any_low  = ~&row_s2;
  assign cand_low = ~row_s2[cand_row];

  // Lowest-numbered low row wins when several rows in a column are pressed.
  always_comb begin
    low_idx = 2'd3;
    if (!row_s2[0])      low_idx = 2'd0;
    else if (!row_s2[1]) low_idx = 2'd1;
    else if (!row_s2[2]) low_idx = 2'd2;
  end

  // Synchronizer and free-running dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1  <= 4'hf;
      row_s2  <= 4'hf;
      div_cnt <= '0;
    end else begin
      row_s1  <= row;
      row_s2  <= row_s1;
      div_cnt <= sample ? '0 : div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_SCAN;
      col_idx  <= 2'd0;
      cand_row <= 2'd0;
      mcnt     <= '0;
      out      <= 4'h0;
      valid    <= 1'b0;
      held     <= 1'b0;
    end else begin
      state    <= state_d;
      col_idx  <= col_idx_d;
      cand_row <= cand_row_d;
      mcnt     <= mcnt_d;
      out      <= out_d;
      valid    <= valid_d;
      held     <= held_d;
    end
  end

  // A full match count is acted on at the clock after it is reached, so the
  // count never needs to grow past DEBOUNCE (increments only happen below it).
  always_comb begin
    state_d    = state;
    col_idx_d  = col_idx;
    cand_row_d = cand_row;
    mcnt_d     = mcnt;
    out_d      = out;
    valid_d    = 1'b0;
    held_d     = held;
    case (state)
      S_SCAN: begin
        if (sample) begin
          if (any_low) begin
            cand_row_d = low_idx;
            mcnt_d     = MW'(1);
            state_d    = S_DEBOUNCE;
          end else begin
            col_idx_d = col_idx + 2'd1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (mcnt == MATCH_MAX) begin
          out_d   = {cand_row, col_idx};
          valid_d = 1'b1;
          held_d  = 1'b1;
          mcnt_d  = '0;
          state_d = S_PRESSED;
        end else if (sample) begin
          if (cand_low) begin
            mcnt_d = mcnt + MW'(1);
          end else begin
            mcnt_d    = '0;
            col_idx_d = col_idx + 2'd1;
            state_d   = S_SCAN;
          end
        end
      end
      S_PRESSED: begin
        if (sample && !cand_low) begin
          mcnt_d  = MW'(1);
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (mcnt == MATCH_MAX) begin
          held_d    = 1'b0;
          col_idx_d = 2'd0;
          mcnt_d    = '0;
          state_d   = S_SCAN;
        end else if (sample) begin
          if (!cand_low) begin
            mcnt_d = mcnt + MW'(1);
          end else begin
            mcnt_d  = '0;
            state_d = S_PRESSED;
          end
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - directed self-checking bench for keypad_encoder
module tb_keypad_encoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  out;
  logic        valid;
  logic        held;
  logic [15:0] keymask;   // bit r*4+c set = key at row r, column c pressed
  int          checks;
  int          passed;
  int          valid_count;

  keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .col   (col),
    .out   (out),
    .valid (valid),
    .held  (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad matrix: a pressed key pulls its row low when its column is driven.
  always_comb begin
    row = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keymask[r*4+c] && col[c] == 1'b0) row[r] = 1'b0;
  end

  always @(negedge clk) if (valid === 1'b1) valid_count++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_held(input logic v, input int max, input string tag);
    int n = 0;
    while (held !== v && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(held), 16'(v));
  endtask

  initial begin
    int n;
    checks      = 0;
    passed      = 0;
    valid_count = 0;
    keymask     = 16'h0000;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_col",   16'(col),   16'h000e);
    check("reset_out",   16'(out),   16'h0000);
    check("reset_valid", 16'(valid), 16'h0000);
    check("reset_held",  16'(held),  16'h0000);
    rst_n = 1'b1;

    // Row 2, column 1 -> code 9.
    keymask = 16'h0200;
    wait_held(1'b1, 300, "press9_held");
    check("press9_valid", 16'(valid), 16'h0001);
    repeat (40) @(negedge clk);
    check("press9_out",    16'(out),    16'h0009);
    check("press9_col",    16'(col),    16'h000d);
    check("press9_vstrb",  16'(valid),  16'h0000);
    check("press9_vcount", 16'(valid_count), 16'd1);

    // Release needs three high samples before held drops.
    keymask = 16'h0000;
    repeat (4) @(negedge clk);
    check("release_early_held", 16'(held), 16'h0001);
    wait_held(1'b0, 100, "release_held");
    check("release_col",    16'(col), 16'h000e);
    check("release_out",    16'(out), 16'h0009);
    check("release_vcount", 16'(valid_count), 16'd1);

    // One-sample bounce on row 0 while column 3 is driven.
    n = 0;
    while (col !== 4'b0111 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bounce_reach_col3", 16'(col), 16'h0007);
    keymask = 16'h0008;
    repeat (4) @(negedge clk);
    keymask = 16'h0000;
    repeat (4) @(negedge clk);
    check("bounce_col",    16'(col),  16'h000e);
    check("bounce_held",   16'(held), 16'h0000);
    check("bounce_out",    16'(out),  16'h0009);
    check("bounce_vcount", 16'(valid_count), 16'd1);

    // Rows 1 and 3 both low in column 2: row 1 wins -> code 6.
    keymask = 16'h4040;
    wait_held(1'b1, 300, "multi_held");
    repeat (2) @(negedge clk);
    check("multi_out",    16'(out), 16'h0006);
    check("multi_col",    16'(col), 16'h000b);
    check("multi_vcount", 16'(valid_count), 16'd2);
    keymask = 16'h0000;
    wait_held(1'b0, 200, "multi_release");

    // Row 3, column 0 held ~200 samples with a one-sample release glitch.
    keymask = 16'h1000;
    wait_held(1'b1, 300, "long_held");
    repeat (400) @(negedge clk);
    keymask = 16'h0000;
    repeat (4) @(negedge clk);
    keymask = 16'h1000;
    repeat (12) @(negedge clk);
    check("glitch_held", 16'(held), 16'h0001);
    repeat (388) @(negedge clk);
    check("long_out",    16'(out),  16'h000c);
    check("long_held2",  16'(held), 16'h0001);
    check("long_vcount", 16'(valid_count), 16'd3);
    keymask = 16'h0000;
    wait_held(1'b0, 200, "long_release");

    // Reset while row 0, column 1 is pressed, then re-acceptance.
    keymask = 16'h0002;
    wait_held(1'b1, 300, "pre_reset_held");
    repeat (2) @(negedge clk);
    check("pre_reset_out", 16'(out), 16'h0001);
    rst_n = 1'b0;
    #1;
    check("async_rst_col",   16'(col),   16'h000e);
    check("async_rst_out",   16'(out),   16'h0000);
    check("async_rst_valid", 16'(valid), 16'h0000);
    check("async_rst_held",  16'(held),  16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_held(1'b1, 300, "reaccept_held");
    repeat (2) @(negedge clk);
    check("reaccept_out",    16'(out), 16'h0001);
    check("reaccept_col",    16'(col), 16'h000d);
    check("reaccept_vcount", 16'(valid_count), 16'd5);
    keymask = 16'h0000;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
